// File: rtl/i2c_pkg.sv
// Shared I2C definitions: slave FSM state encodings (also decoded by the master's
// state_debug viewer), ACK/NACK bit values and the default device address.
package i2c_pkg;

    typedef enum logic [3:0] {
        StIdle    = 4'd0,
        StDevAddr = 4'd1,
        StDevAck  = 4'd2,
        StRegAddr = 4'd3,
        StRegAck  = 4'd4,
        StWrData  = 4'd5,
        StWrAck   = 4'd6,
        StRdData  = 4'd7,
        StRdAck   = 4'd8,
        StIgnore  = 4'd9
    } i2c_state_e;

    localparam logic       I2cAck         = 1'b0;
    localparam logic       I2cNack        = 1'b1;
    localparam logic [6:0] DefaultDevAddr = 7'h50;

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA conditioning in the clk_12m domain: 2-FF synchronizers, one history flop,
// and single-cycle scl_rise/scl_fall/start/stop pulses.
module i2c_line_sync (
    input  logic clk_12m,
    input  logic rst_n,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop,
    output logic sda_s
);

    logic [2:0] scl_q;
    logic [2:0] sda_q;

    // Idle bus is high, so reset the pipelines to 1 to avoid a false edge after reset.
    always_ff @(posedge clk_12m or negedge rst_n) begin
        if (!rst_n) begin
            scl_q <= '1;
            sda_q <= '1;
        end else begin
            scl_q <= {scl_q[1:0], scl};
            sda_q <= {sda_q[1:0], sda};
        end
    end

    // Bit 1 is the current synchronized sample, bit 2 its history.
    assign scl_rise = scl_q[1] & ~scl_q[2];
    assign scl_fall = ~scl_q[1] & scl_q[2];
    assign start    = scl_q[2] & scl_q[1] & sda_q[2] & ~sda_q[1];
    assign stop     = scl_q[2] & scl_q[1] & ~sda_q[2] & sda_q[1];
    assign sda_s    = sda_q[1];

endmodule

// File: rtl/i2c_slave_eeprom.sv
// I2C responder emulating a 256-byte AT24C02-class EEPROM: byte/sequential write,
// random read and current-address sequential read, oversampled from clk_12m.
module i2c_slave_eeprom
    import i2c_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR  = DefaultDevAddr,
    parameter int unsigned MEM_DEPTH = 256
) (
    input  logic       clk_12m,
    input  logic       rst_n,
    input  logic       scl,
    inout  wire        sda,
    output logic       wr_pulse,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       rd_pulse,
    output logic       busy,
    output logic [7:0] state_debug
);

    logic scl_rise, scl_fall, start_det, stop_det, sda_in;

    i2c_line_sync u_line_sync (
        .clk_12m  (clk_12m),
        .rst_n    (rst_n),
        .scl      (scl),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start_det),
        .stop     (stop_det),
        .sda_s    (sda_in)
    );

    i2c_state_e state_q;
    logic [3:0] bit_cnt_q;
    logic [7:0] shift_q;
    logic [7:0] ptr_q;
    logic       sda_oe_q;
    logic       rw_q;
    logic [7:0] rx_byte;
    logic [7:0] ptr_inc;
    logic       mem_we;
    logic [7:0] mem [MEM_DEPTH];

    assign rx_byte     = {shift_q[6:0], sda_in};
    assign ptr_inc     = (ptr_q == 8'(MEM_DEPTH - 1)) ? 8'h00 : ptr_q + 8'd1;
    assign mem_we      = (state_q == StWrData) && scl_rise && (bit_cnt_q == 4'd7);
    assign sda         = sda_oe_q ? 1'b0 : 1'bz;
    assign state_debug = {4'h0, state_q};

    // Storage is deliberately not reset.
    always_ff @(posedge clk_12m) begin
        if (mem_we) begin
            mem[ptr_q] <= rx_byte;
        end
    end

    always_ff @(posedge clk_12m or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            ptr_q     <= '0;
            sda_oe_q  <= 1'b0;
            rw_q      <= 1'b0;
            wr_pulse  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            rd_pulse  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            wr_pulse <= 1'b0;
            rd_pulse <= 1'b0;
            if (start_det) begin
                state_q   <= StDevAddr;
                bit_cnt_q <= '0;
                sda_oe_q  <= 1'b0;
            end else if (stop_det) begin
                state_q  <= StIdle;
                sda_oe_q <= 1'b0;
                busy     <= 1'b0;
            end else begin
                case (state_q)
                    StDevAddr, StRegAddr, StWrData: begin
                        if (scl_rise) begin
                            shift_q   <= rx_byte;
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            if (bit_cnt_q == 4'd7) begin
                                bit_cnt_q <= '0;
                                if (state_q == StDevAddr) begin
                                    if (rx_byte[7:1] == DEV_ADDR) begin
                                        state_q <= StDevAck;
                                        rw_q    <= rx_byte[0];
                                        busy    <= 1'b1;
                                    end else begin
                                        state_q <= StIgnore;
                                        busy    <= 1'b0;
                                    end
                                end else if (state_q == StRegAddr) begin
                                    ptr_q   <= rx_byte;
                                    state_q <= StRegAck;
                                end else begin
                                    wr_addr  <= ptr_q;
                                    wr_data  <= rx_byte;
                                    wr_pulse <= 1'b1;
                                    ptr_q    <= ptr_inc;
                                    state_q  <= StWrAck;
                                end
                            end
                        end
                    end
                    // First fall asserts ACK, second fall releases it. A read skips the
                    // release: data is loaded on the 9th rise and its MSB replaces ACK.
                    StDevAck, StRegAck, StWrAck: begin
                        if (scl_fall) begin
                            if (!sda_oe_q) begin
                                sda_oe_q <= 1'b1;
                            end else begin
                                sda_oe_q  <= 1'b0;
                                bit_cnt_q <= '0;
                                state_q   <= (state_q == StDevAck) ? StRegAddr : StWrData;
                            end
                        end else if (scl_rise && sda_oe_q && rw_q && (state_q == StDevAck)) begin
                            shift_q   <= mem[ptr_q];
                            rd_pulse  <= 1'b1;
                            bit_cnt_q <= '0;
                            state_q   <= StRdData;
                        end
                    end
                    StRdData: begin
                        if (scl_fall) begin
                            if (bit_cnt_q == 4'd8) begin
                                sda_oe_q  <= 1'b0;
                                bit_cnt_q <= '0;
                                state_q   <= StRdAck;
                            end else begin
                                sda_oe_q  <= ~shift_q[7];
                                shift_q   <= {shift_q[6:0], 1'b0};
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                            end
                        end
                    end
                    StRdAck: begin
                        if (scl_rise) begin
                            ptr_q <= ptr_inc;
                            if (sda_in == I2cAck) begin
                                shift_q   <= mem[ptr_inc];
                                rd_pulse  <= 1'b1;
                                bit_cnt_q <= '0;
                                state_q   <= StRdData;
                            end else begin
                                state_q <= StIgnore;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
